alu_op_scheduler: RTL and testbench



---
 rtl/alu_op_scheduler.sv | 104 ++++++++++
 tb/tb_alu_op_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin two-requester sequencer that issues one ALU op per grant and returns a done pulse.
module alu_op_scheduler #(
  parameter int OP_W = 6,
  parameter int D_W  = 5,
  parameter int R_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic [OP_W-1:0] op0,
  input  logic [D_W-1:0]  a0,
  input  logic [D_W-1:0]  b0,
  input  logic            req1,
  input  logic [OP_W-1:0] op1,
  input  logic [D_W-1:0]  a1,
  input  logic [D_W-1:0]  b1,
  output logic [OP_W-1:0] alu_sel,
  output logic [D_W-1:0]  alu_a,
  output logic [D_W-1:0]  alu_b,
  input  logic [R_W-1:0]  alu_result,
  output logic            done0,
  output logic            done1,
  output logic [R_W-1:0]  result,
  output logic            parity,
  output logic            err,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d, op_w;
  logic [D_W-1:0]  a_q, a_d, b_q, b_d;
  logic            gnt_q, gnt_d, last_q, last_d, pick, legal;
  logic [R_W-1:0]  result_q, result_d;
  logic            parity_q, parity_d, err_q, err_d;
  // Contention goes to the requester that did not win last time.
  always_comb begin
    pick  = (req0 && req1) ? ~last_q : req1;
    op_w  = pick ? op1 : op0;
    legal = (op_w != '0) && ((op_w & (op_w - OP_W'(1))) == '0);
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    result_d = result_q;
    parity_d = parity_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req0 || req1) begin
        op_d    = op_w;
        a_d     = pick ? a1 : a0;
        b_d     = pick ? b1 : b0;
        gnt_d   = pick;
        last_d  = pick;
        state_d = legal ? ISSUE : RESP;
        if (!legal) begin
          result_d = '0;
          parity_d = 1'b0;
          err_d    = 1'b1;
        end
      end
      ISSUE: begin
        result_d = alu_result;
        parity_d = ~^alu_result[5:0];
        err_d    = 1'b0;
        state_d  = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      result_q <= result_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end
  assign alu_sel = (state_q == ISSUE) ? op_q : '0;
  assign alu_a   = (state_q == ISSUE) ? a_q : '0;
  assign alu_b   = (state_q == ISSUE) ? b_q : '0;
  assign done0   = (state_q == RESP) && !gnt_q;
  assign done1   = (state_q == RESP) && gnt_q;
  assign result  = result_q;
  assign parity  = parity_q;
  assign err     = err_q;
  assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: scoreboard bench with a small external ALU (000001 = add, 000010 = xor, 6-bit sign-extended).
module tb_alu_op_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [5:0]  op0 = '0, op1 = '0, alu_sel;
  logic [4:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0, alu_a, alu_b;
  logic [31:0] alu_result, result;
  logic        done0, done1, parity, err, busy;
  int          checks = 0, errors = 0, cyc = 0;
  typedef struct packed {logic [1:0] dn; logic [31:0] res; logic par; logic er;} exp_t;
  exp_t        sb[$];
  exp_t        mon_e;

  alu_op_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .done0(done0), .done1(done1), .result(result), .parity(parity), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] alu_fn(input logic [5:0] sel, input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = (sel == 6'b000001) ? 6'(a) + 6'(b) : (sel == 6'b000010) ? 6'(a ^ b) : 6'd0;
    return {{26{s[5]}}, s};
  endfunction
  assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

  always @(negedge clk) if (rst_n && (done0 || done1)) begin
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done got done1/done0=%b%b with empty scoreboard", done1, done0);
    end else begin
      mon_e = sb.pop_front();
      if ({done1, done0} !== mon_e.dn || result !== mon_e.res || parity !== mon_e.par || err !== mon_e.er) begin
        errors++;
        $display("FAIL completion got done=%b result=%h parity=%b err=%b expected done=%b result=%h parity=%b err=%b",
                 {done1, done0}, result, parity, err, mon_e.dn, mon_e.res, mon_e.par, mon_e.er);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_sel, alu_a, alu_b, done0, done1, result, parity, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state got sel=%b a=%0d b=%0d d0=%b d1=%b res=%h par=%b err=%b busy=%b expected all zero",
               alu_sel, alu_a, alu_b, done0, done1, result, parity, err, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit got = 0;
    @(negedge clk);
    req0 = 1; op0 = 6'b000001; a0 = 7; b0 = 9;
    sb.push_back(exp_t'{2'b01, 32'h00000010, 1'b0, 1'b0});
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (alu_sel !== 6'b000001 || alu_a !== 5'd7 || alu_b !== 5'd9 || busy !== 1'b1) begin
          errors++;
          $display("FAIL issue_drive got sel=%b a=%0d b=%0d busy=%b expected 000001 7 9 1", alu_sel, alu_a, alu_b, busy);
        end
      end
      if (done0 || done1) begin
        got = 1;
        checks++;
        if (i != 1) begin errors++; $display("FAIL done_latency got cycle %0d expected 1", i); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL single_timeout got no done expected done0"); end
    req0 = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || alu_sel !== '0 || result !== 32'h10) begin
      errors++;
      $display("FAIL idle_hold got busy=%b sel=%b result=%h expected 0 000000 00000010", busy, alu_sel, result);
    end
  endtask

  task automatic test_parity();
    logic [1:0]  who [2] = '{2'b01, 2'b10};
    logic [4:0]  av  [2] = '{5'd31, 5'd3};
    logic [4:0]  bv  [2] = '{5'd31, 5'd0};
    logic [31:0] rv  [2] = '{32'hFFFFFFFE, 32'h00000003};
    logic        pv  [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      bit got = 0;
      @(negedge clk);
      if (who[k][0]) begin req0 = 1; op0 = 6'b000001; a0 = av[k]; b0 = bv[k]; end
      else begin req1 = 1; op1 = 6'b000001; a1 = av[k]; b1 = bv[k]; end
      sb.push_back(exp_t'{who[k], rv[k], pv[k], 1'b0});
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        got = done0 || done1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL parity_timeout case %0d got no done", k); end
      req0 = 0; req1 = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    int n = 0, prev = 0;
    @(negedge clk);
    req0 = 1; op0 = 6'b000001; a0 = 1; b0 = 2;
    req1 = 1; op1 = 6'b000001; a1 = 4; b1 = 3;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(exp_t'{2'b01, 32'h3, 1'b1, 1'b0});
      sb.push_back(exp_t'{2'b10, 32'h7, 1'b0, 1'b0});
    end
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        if (n > 0) begin
          checks++;
          if (cyc - prev != 3) begin errors++; $display("FAIL fair_spacing got %0d cycles expected 3", cyc - prev); end
        end
        prev = cyc;
        n++;
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL fair_count got %0d dones expected 4", n); end
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bit got = 0;
    @(negedge clk);
    req0 = 1; op0 = 6'b000011; a0 = 5; b0 = 5;
    sb.push_back(exp_t'{2'b01, 32'h0, 1'b0, 1'b1});
    @(negedge clk);
    checks++;
    if (alu_sel !== '0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL illegal_resp got sel=%b done0=%b expected 000000 1", alu_sel, done0);
    end
    req0 = 0;
    @(negedge clk);
    req0 = 1; op0 = 6'b000010; a0 = 6; b0 = 3;
    sb.push_back(exp_t'{2'b01, 32'h5, 1'b1, 1'b0});
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = done0 || done1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL recover_timeout got no done expected done0"); end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_issue();
    bit got = 0;
    @(negedge clk);
    req0 = 1; op0 = 6'b000001; a0 = 2; b0 = 4;
    @(posedge clk);
    #2;
    checks++;
    if (alu_sel !== 6'b000001) begin errors++; $display("FAIL pre_reset_issue got sel=%b expected 000001", alu_sel); end
    rst_n = 0;
    #1;
    checks++;
    if ({alu_sel, alu_a, alu_b, done0, done1, result, parity, err, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset got sel=%b d0=%b res=%h err=%b busy=%b expected all zero", alu_sel, done0, result, err, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_hold got done0=%b busy=%b expected 0 0", done0, busy); end
    rst_n = 1;
    sb.push_back(exp_t'{2'b01, 32'h6, 1'b1, 1'b0});
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = done0 || done1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL post_reset_timeout got no done expected done0"); end
    req0 = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_fairness();
    test_illegal();
    test_reset_issue();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
